multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 256, maximum wait cycles for mem_ready in FETCH/MEM; legal range 2..65535.
REQ-002 Parameter: OPCODE_W, 11, opcode width; decode uses opcode[OPCODE_W-1:OPCODE_W-11], lower bits ignored.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 opcode  input  OPCODE_W  instruction opcode field from the instruction register; sampled only in DECODE.
REQ-006 mem_ready  input  1  memory completion strobe; honoured only in FETCH and MEM.
REQ-007 ir_write, pc_write  output  1 each  instruction-register load and PC+4 update strobes.
REQ-008 mem_read, mem_write, reg_write, alu_src, update_sreg, readreg2_control, write_reg_src  output  1 each  datapath controls, same meaning as the single-cycle decoder.
REQ-009 alu_op, mem_to_reg  output  2 each; branch_op  output  3  (000 none, 001 B, 010 B.cond, 011 CBZ, 100 CBNZ).
REQ-010 illegal_op  output  1  one-cycle pulse on an unrecognised opcode; mem_timeout  output  1  sticky fault flag; state  output  3  current FSM state.

Function
REQ-011 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; outputs SHALL be Moore, decoded from state plus a class register latched in DECODE, with no combinational opcode-to-output path.
REQ-012 FETCH: mem_read=1 until mem_ready; in the mem_ready cycle ir_write=1 and pc_write=1 for exactly that cycle, next state DECODE.
REQ-013 DECODE: one cycle; latch class (R, R-flags, I, I-flags, CMP, CMPI, LOAD, STORE, CBZ, CBNZ, B, BCOND, BL, ILLEGAL) from opcode; ILLEGAL -> illegal_op=1 for one cycle, next FETCH; otherwise next EXEC.
REQ-014 EXEC: alu_op=10 for ALU/compare classes, 00 for LOAD/STORE, 01 for branch classes; alu_src=1 for I, I-flags, CMPI, LOAD, STORE; readreg2_control=1 for STORE, CBZ, CBNZ; update_sreg=1 for R-flags, I-flags, CMP, CMPI, CBZ, CBNZ; branch_op driven per class.
REQ-015 EXEC exits: R, R-flags, I, I-flags, BL -> WB; LOAD, STORE -> MEM; CMP, CMPI, CBZ, CBNZ, B, BCOND -> FETCH.
REQ-016 MEM: LOAD holds mem_read=1, STORE holds mem_write=1 and readreg2_control=1, alu_src=1, until mem_ready; then LOAD -> WB, STORE -> FETCH.
REQ-017 WB: reg_write=1 for one cycle; mem_to_reg=01 for LOAD, 10 with write_reg_src=1 for BL, 00 otherwise; next FETCH.
REQ-018 Each control SHALL be 0 in every state/class not listed; update_sreg and branch_op SHALL assert for exactly one cycle per instruction.
REQ-019 Instruction latency without waits: ALU 4 cycles, LOAD 5, STORE 4, compare/branch 3, illegal 2.
REQ-020 mem_ready SHALL be ignored in DECODE, EXEC, WB and FAULT; mem_ready held high continuously SHALL give zero-wait transfers.
REQ-021 FAULT: all controls 0, mem_timeout=1, state held until reset.

Reset
REQ-022 reset high at a clock edge SHALL force state FETCH, class ILLEGAL-cleared to R, wait counter 0, mem_timeout 0, all strobes 0, overriding any in-progress transfer.
REQ-023 reset asserted mid-MEM SHALL deassert mem_write/mem_read on the first cycle after that edge; FETCH mem_read reasserts the cycle after reset releases.

Configuration
REQ-024 Macro MULTICYCLE_TIMEOUT_EN defined: a wait counter increments each cycle in FETCH/MEM without mem_ready, clears on mem_ready or state exit; reaching TIMEOUT_CYCLES SHALL enter FAULT next cycle.
REQ-025 Macro MULTICYCLE_TIMEOUT_EN undefined: no counter, FAULT unreachable, mem_timeout tied 0, waits unbounded.

Verification
REQ-026 ADD opcode, mem_ready always 1 -> states 0,1,2,4,0; reg_write=1 only in WB, alu_op=10 in EXEC, ir_write/pc_write one cycle each.
REQ-027 LDUR, mem_ready low 3 cycles in MEM -> mem_read high 4 MEM cycles, then WB with mem_to_reg=01, reg_write=1, total 8 cycles.
REQ-028 CBNZ -> EXEC shows readreg2_control=1, update_sreg=1, branch_op=100 for one cycle, then FETCH; reg_write never asserts.
REQ-029 Opcode 11'h000 -> illegal_op=1 in DECODE cycle, return to FETCH, no other strobe asserted.
REQ-030 With MULTICYCLE_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> state 5 and mem_timeout=1 after 4 wait cycles; reset returns state 0, mem_timeout 0.
REQ-031 STUR with reset pulsed in second MEM cycle -> mem_write=0 next cycle, state=0, then normal fetch.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Control FSM for a multicycle LEGv8-style datapath. Each instruction
//   walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB] and returns to FETCH.
//   The instruction class is latched in DECODE. EXEC, MEM and WB outputs
//   are decoded from the current state and that class register. The one
//   exception is illegal_op in DECODE, which is decoded directly from the
//   opcode.
//
//   Optional build macro: MULTICYCLE_TIMEOUT_EN
//     defined   - FETCH/MEM waits are bounded by TIMEOUT_CYCLES. On expiry
//                 the FSM enters FAULT and stays there until reset.
//     undefined - no wait counter, FAULT unreachable, mem_timeout tied 0.
//
//   Parameters
//     TIMEOUT_CYCLES  max wait cycles for mem_ready (2..65535)
//     OPCODE_W        opcode width; only the top 11 bits are decoded
//
//   Ports
//     clk, reset        clock, synchronous active-high reset
//     opcode            instruction opcode, sampled only in DECODE
//     mem_ready         memory completion strobe (FETCH and MEM only)
//     ir_write/pc_write IR load and PC+4 strobes (FETCH ready cycle)
//     mem_read/mem_write, reg_write, alu_src, update_sreg,
//     readreg2_control, write_reg_src, alu_op, mem_to_reg, branch_op
//                       datapath controls
//     illegal_op        one-cycle pulse on an unrecognised opcode
//     mem_timeout       sticky fault flag (FAULT state)
//     state             current FSM state
//
//   Opcode map (top 11 bits, x = ignored):
//     R      ADD 10001011000, SUB 11001011000, AND 10001010000,
//            ORR 10101010000, EOR 11001010000
//     R-flg  ADDS 10101011000, SUBS 11101011000, ANDS 11101010000
//     CMP    11101011001
//     I      ADDI 1001000100x, SUBI 1101000100x, ANDI 1001001000x,
//            ORRI 1011001000x, EORI 1101001000x
//     I-flg  ADDIS 1011000100x, SUBIS 1111000100x, ANDIS 1111001000x
//     CMPI   1111000110x
//     LDUR   11111000010, STUR 11111000000
//     CBZ    10110100xxx, CBNZ 10110101xxx, B.cond 01010100xxx
//     B      000101xxxxx, BL 100101xxxxx
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned OPCODE_W       = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                ir_write,
    output logic                pc_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                alu_src,
    output logic                update_sreg,
    output logic                readreg2_control,
    output logic                write_reg_src,
    output logic [1:0]          alu_op,
    output logic [1:0]          mem_to_reg,
    output logic [2:0]          branch_op,
    output logic                illegal_op,
    output logic                mem_timeout,
    output logic [2:0]          state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    localparam logic [3:0] C_R       = 4'd0;
    localparam logic [3:0] C_RF      = 4'd1;
    localparam logic [3:0] C_I       = 4'd2;
    localparam logic [3:0] C_IF      = 4'd3;
    localparam logic [3:0] C_CMP     = 4'd4;
    localparam logic [3:0] C_CMPI    = 4'd5;
    localparam logic [3:0] C_LOAD    = 4'd6;
    localparam logic [3:0] C_STORE   = 4'd7;
    localparam logic [3:0] C_CBZ     = 4'd8;
    localparam logic [3:0] C_CBNZ    = 4'd9;
    localparam logic [3:0] C_B       = 4'd10;
    localparam logic [3:0] C_BCOND   = 4'd11;
    localparam logic [3:0] C_BL      = 4'd12;
    localparam logic [3:0] C_ILLEGAL = 4'd13;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("multicycle_control: TIMEOUT_CYCLES must be 2..65535");
    end
    if (OPCODE_W < 11) begin : g_bad_opcode_w
        $error("multicycle_control: OPCODE_W must be at least 11");
    end

    logic [10:0] op_top;
    logic [3:0]  dec_class;
    logic [3:0]  cls;
    logic [3:0]  cls_next;
    logic [2:0]  state_next;
    logic        wait_expired;

    assign op_top = opcode[OPCODE_W-1 -: 11];

    always_comb begin
        dec_class = C_ILLEGAL;
        casez (op_top)
            11'b10001011000, 11'b11001011000, 11'b10001010000,
            11'b10101010000, 11'b11001010000:                 dec_class = C_R;
            11'b10101011000, 11'b11101011000, 11'b11101010000: dec_class = C_RF;
            11'b11101011001:                                   dec_class = C_CMP;
            11'b1001000100?, 11'b1101000100?, 11'b1001001000?,
            11'b1011001000?, 11'b1101001000?:                 dec_class = C_I;
            11'b1011000100?, 11'b1111000100?, 11'b1111001000?: dec_class = C_IF;
            11'b1111000110?:                                   dec_class = C_CMPI;
            11'b11111000010:                                   dec_class = C_LOAD;
            11'b11111000000:                                   dec_class = C_STORE;
            11'b10110100???:                                   dec_class = C_CBZ;
            11'b10110101???:                                   dec_class = C_CBNZ;
            11'b01010100???:                                   dec_class = C_BCOND;
            11'b000101?????:                                   dec_class = C_B;
            11'b100101?????:                                   dec_class = C_BL;
            default:                                           dec_class = C_ILLEGAL;
        endcase
    end

`ifdef MULTICYCLE_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    // Counts consecutive FETCH/MEM cycles without mem_ready; any other
    // state or a ready cycle restarts the count.
    always_ff @(posedge clk) begin
        if (reset || mem_ready || !(state == S_FETCH || state == S_MEM))
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 16'd1;
    end

    assign wait_expired = (wait_cnt == WAIT_LAST);
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cls_next   = cls;
        case (state)
            S_FETCH: begin
                if (mem_ready)
                    state_next = S_DECODE;
                else if (wait_expired)
                    state_next = S_FAULT;
            end
            S_DECODE: begin
                cls_next   = dec_class;
                state_next = (dec_class == C_ILLEGAL) ? S_FETCH : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD, C_STORE:               state_next = S_MEM;
                    C_R, C_RF, C_I, C_IF, C_BL:    state_next = S_WB;
                    default:                       state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ready)
                    state_next = (cls == C_LOAD) ? S_WB : S_FETCH;
                else if (wait_expired)
                    state_next = S_FAULT;
            end
            S_WB:    state_next = S_FETCH;
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cls   <= C_R;
        end else begin
            state <= state_next;
            cls   <= cls_next;
        end
    end

    // Strobes are forced low while reset is held so that no transfer is
    // requested until the first cycle after reset releases.
    always_comb begin
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        reg_write        = 1'b0;
        alu_src          = 1'b0;
        update_sreg      = 1'b0;
        readreg2_control = 1'b0;
        write_reg_src    = 1'b0;
        alu_op           = 2'b00;
        mem_to_reg       = 2'b00;
        branch_op        = 3'b000;
        illegal_op       = 1'b0;
        mem_timeout      = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                // The class register is not yet loaded in DECODE, so the
                // illegal pulse comes straight from the opcode decode.
                S_DECODE: illegal_op = (dec_class == C_ILLEGAL);
                S_EXEC: begin
                    case (cls)
                        C_LOAD, C_STORE:                   alu_op = 2'b00;
                        C_CBZ, C_CBNZ, C_B, C_BCOND, C_BL: alu_op = 2'b01;
                        default:                           alu_op = 2'b10;
                    endcase
                    alu_src = (cls == C_I) || (cls == C_IF) || (cls == C_CMPI) ||
                              (cls == C_LOAD) || (cls == C_STORE);
                    readreg2_control = (cls == C_STORE) || (cls == C_CBZ) || (cls == C_CBNZ);
                    update_sreg = (cls == C_RF) || (cls == C_IF) || (cls == C_CMP) ||
                                  (cls == C_CMPI) || (cls == C_CBZ) || (cls == C_CBNZ);
                    case (cls)
                        C_B, C_BL: branch_op = 3'b001;
                        C_BCOND:   branch_op = 3'b010;
                        C_CBZ:     branch_op = 3'b011;
                        C_CBNZ:    branch_op = 3'b100;
                        default:   branch_op = 3'b000;
                    endcase
                end
                S_MEM: begin
                    if (cls == C_LOAD) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write        = 1'b1;
                        readreg2_control = 1'b1;
                        alu_src          = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (cls == C_LOAD) begin
                        mem_to_reg = 2'b01;
                    end else if (cls == C_BL) begin
                        mem_to_reg    = 2'b10;
                        write_reg_src = 1'b1;
                    end
                end
`ifdef MULTICYCLE_TIMEOUT_EN
                S_FAULT: mem_timeout = 1'b1;
`endif
                default: ;
            endcase
        end
    end

endmodule
